// File: rtl/match_controller.sv
// match_controller: round sequencer for a two-player match.
// It runs the 3-2-1 countdown, gates movement, detects blast-zone KOs,
// holds KO'd players at spawn, counts stocks and declares the winner.
// All state advances on frame_tick; start edges are seen on any clk.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   frame_tick          one-clk strobe per video frame
//   start_button        level input; rising edge starts a match or skips results
//   p1_x/p1_y/p2_x/p2_y 10-bit player positions
//   run_en              movement enable for both movement FSMs
//   p1_respawn/p2_respawn  player held at spawn
//   p1_stocks/p2_stocks    remaining lives
//   countdown           countdown digit (3,2,1) or 0
//   game_over, winner   result (winner: 0 none, 1 P1, 2 P2, 3 draw)
module match_controller #(
    parameter int unsigned STOCKS          = 3,
    parameter int unsigned COUNT_FRAMES    = 60,
    parameter int unsigned RESPAWN_FRAMES  = 90,
    parameter int unsigned GAMEOVER_FRAMES = 180,
    parameter int unsigned BLAST_X_MAX     = 630,
    parameter int unsigned BLAST_Y_MAX     = 470
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_button,
    input  logic [9:0] p1_x,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_x,
    input  logic [9:0] p2_y,
    output logic       run_en,
    output logic       p1_respawn,
    output logic       p2_respawn,
    output logic [1:0] p1_stocks,
    output logic [1:0] p2_stocks,
    output logic [1:0] countdown,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] COUNTDOWN = 3'd1;
    localparam logic [2:0] PLAY      = 3'd2;
    localparam logic [2:0] RESPAWN   = 3'd3;
    localparam logic [2:0] GAME_OVER = 3'd4;

    localparam logic [7:0] CD_LAST = 8'(COUNT_FRAMES - 1);
    localparam logic [7:0] RS_LAST = 8'(RESPAWN_FRAMES - 1);
    localparam logic [7:0] GO_LAST = 8'(GAMEOVER_FRAMES - 1);
    localparam logic [1:0] STOCK_INIT = 2'(STOCKS);
    localparam logic [9:0] X_MAX = 10'(BLAST_X_MAX);
    localparam logic [9:0] Y_MAX = 10'(BLAST_Y_MAX);

    logic [2:0] state, state_nxt;
    logic [7:0] frame_cnt, cnt_nxt;
    logic       start_prev;
    logic       start_edge;
    logic       run_en_nxt, p1_respawn_nxt, p2_respawn_nxt, game_over_nxt;
    logic [1:0] p1_stocks_nxt, p2_stocks_nxt, countdown_nxt, winner_nxt;
    logic       ko1, ko2;
    logic [1:0] st1_dec, st2_dec;

    assign start_edge = start_button & ~start_prev;

    // Blast-zone test; x above X_MAX also catches wrap-around below 0
    assign ko1 = (p1_x > X_MAX) | (p1_y > Y_MAX);
    assign ko2 = (p2_x > X_MAX) | (p2_y > Y_MAX);

    // Saturating stock decrement for KO'd players
    assign st1_dec = (ko1 && p1_stocks != 2'd0) ? p1_stocks - 2'd1 : p1_stocks;
    assign st2_dec = (ko2 && p2_stocks != 2'd0) ? p2_stocks - 2'd1 : p2_stocks;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            frame_cnt  <= 8'd0;
            start_prev <= 1'b0;
            run_en     <= 1'b0;
            p1_respawn <= 1'b0;
            p2_respawn <= 1'b0;
            p1_stocks  <= STOCK_INIT;
            p2_stocks  <= STOCK_INIT;
            countdown  <= 2'd0;
            game_over  <= 1'b0;
            winner     <= 2'd0;
        end else begin
            state      <= state_nxt;
            frame_cnt  <= cnt_nxt;
            start_prev <= start_button;
            run_en     <= run_en_nxt;
            p1_respawn <= p1_respawn_nxt;
            p2_respawn <= p2_respawn_nxt;
            p1_stocks  <= p1_stocks_nxt;
            p2_stocks  <= p2_stocks_nxt;
            countdown  <= countdown_nxt;
            game_over  <= game_over_nxt;
            winner     <= winner_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = frame_cnt;
        run_en_nxt     = run_en;
        p1_respawn_nxt = p1_respawn;
        p2_respawn_nxt = p2_respawn;
        p1_stocks_nxt  = p1_stocks;
        p2_stocks_nxt  = p2_stocks;
        countdown_nxt  = countdown;
        game_over_nxt  = game_over;
        winner_nxt     = winner;

        case (state)
            IDLE: begin
                run_en_nxt = 1'b0;
                cnt_nxt    = 8'd0;
                if (start_edge) begin
                    p1_stocks_nxt = STOCK_INIT;
                    p2_stocks_nxt = STOCK_INIT;
                    countdown_nxt = 2'd3;
                    state_nxt     = COUNTDOWN;
                end
            end

            COUNTDOWN: begin
                run_en_nxt = 1'b0;
                if (frame_tick) begin
                    if (frame_cnt == CD_LAST) begin
                        cnt_nxt = 8'd0;
                        if (countdown == 2'd1) begin
                            countdown_nxt = 2'd0;
                            run_en_nxt    = 1'b1;
                            state_nxt     = PLAY;
                        end else begin
                            countdown_nxt = countdown - 2'd1;
                        end
                    end else begin
                        cnt_nxt = frame_cnt + 8'd1;
                    end
                end
            end

            PLAY: begin
                run_en_nxt = 1'b1;
                cnt_nxt    = 8'd0;
                if (frame_tick && (ko1 || ko2)) begin
                    p1_stocks_nxt = st1_dec;
                    p2_stocks_nxt = st2_dec;
                    run_en_nxt    = 1'b0;
                    if (st1_dec == 2'd0 || st2_dec == 2'd0) begin
                        // {p1 out, p2 out}: 01 -> P1 wins, 10 -> P2 wins, 11 -> draw
                        winner_nxt    = {st1_dec == 2'd0, st2_dec == 2'd0};
                        game_over_nxt = 1'b1;
                        state_nxt     = GAME_OVER;
                    end else begin
                        p1_respawn_nxt = ko1;
                        p2_respawn_nxt = ko2;
                        state_nxt      = RESPAWN;
                    end
                end
            end

            RESPAWN: begin
                run_en_nxt = 1'b0;
                if (frame_tick) begin
                    if (frame_cnt == RS_LAST) begin
                        cnt_nxt        = 8'd0;
                        p1_respawn_nxt = 1'b0;
                        p2_respawn_nxt = 1'b0;
                        run_en_nxt     = 1'b1;
                        state_nxt      = PLAY;
                    end else begin
                        cnt_nxt = frame_cnt + 8'd1;
                    end
                end
            end

            GAME_OVER: begin
                run_en_nxt    = 1'b0;
                game_over_nxt = 1'b1;
                if (start_edge || (frame_tick && frame_cnt == GO_LAST)) begin
                    cnt_nxt       = 8'd0;
                    game_over_nxt = 1'b0;
                    winner_nxt    = 2'd0;
                    state_nxt     = IDLE;
                end else if (frame_tick) begin
                    cnt_nxt = frame_cnt + 8'd1;
                end
            end

            default: begin
                state_nxt      = IDLE;
                cnt_nxt        = 8'd0;
                run_en_nxt     = 1'b0;
                p1_respawn_nxt = 1'b0;
                p2_respawn_nxt = 1'b0;
                countdown_nxt  = 2'd0;
                game_over_nxt  = 1'b0;
                winner_nxt     = 2'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: directed self-checking bench for match_controller
// with short frame limits so a whole match fits in a few hundred clocks.
module tb_match_controller;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       start_button;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic       run_en, p1_respawn, p2_respawn, game_over;
    logic [1:0] p1_stocks, p2_stocks, countdown, winner;

    int total;
    int bad;

    match_controller #(
        .STOCKS(3), .COUNT_FRAMES(2), .RESPAWN_FRAMES(3), .GAMEOVER_FRAMES(4),
        .BLAST_X_MAX(630), .BLAST_Y_MAX(470)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_button(start_button),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .run_en(run_en), .p1_respawn(p1_respawn), .p2_respawn(p2_respawn),
        .p1_stocks(p1_stocks), .p2_stocks(p2_stocks), .countdown(countdown),
        .game_over(game_over), .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame_tick seen by exactly one rising edge; returns at a falling edge
    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic press();
        @(negedge clk) start_button = 1'b1;
        @(negedge clk) start_button = 1'b0;
    endtask

    task automatic safe_pos();
        p1_x = 10'd100; p1_y = 10'd100; p2_x = 10'd200; p2_y = 10'd100;
    endtask

    // Start a match and run the full 3-2-1 countdown into PLAY
    task automatic to_play();
        press();
        repeat (6) tick();
    endtask

    int cd_exp[6] = '{3, 3, 2, 2, 1, 1};

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; frame_tick = 1'b0; start_button = 1'b0;
        safe_pos();
        #12;
        check("rst_run_en", int'(run_en), 0);
        check("rst_p1_stocks", int'(p1_stocks), 3);
        check("rst_p2_stocks", int'(p2_stocks), 3);
        check("rst_countdown", int'(countdown), 0);
        check("rst_game_over", int'(game_over), 0);
        @(negedge clk) rst = 1'b0;

        // Ticks in IDLE do nothing
        tick();
        check("idle_countdown", int'(countdown), 0);

        // Countdown sequence
        press();
        check("cd_stocks1", int'(p1_stocks), 3);
        check("cd_stocks2", int'(p2_stocks), 3);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("cd_digit%0d", i), int'(countdown), cd_exp[i]);
            check($sformatf("cd_run%0d", i), int'(run_en), 0);
            if (i == 2) press();   // start ignored mid-countdown
            tick();
        end
        check("play_run_en", int'(run_en), 1);
        check("play_countdown", int'(countdown), 0);

        // Out-of-zone position without a tick changes nothing
        p1_x = 10'd640;
        repeat (3) @(negedge clk);
        check("notick_p1_stocks", int'(p1_stocks), 3);
        check("notick_run_en", int'(run_en), 1);

        // Single KO of p1; stays out of zone during respawn (KO suspended)
        tick();
        check("ko1_p1_stocks", int'(p1_stocks), 2);
        check("ko1_p2_stocks", int'(p2_stocks), 3);
        check("ko1_p1_respawn", int'(p1_respawn), 1);
        check("ko1_p2_respawn", int'(p2_respawn), 0);
        check("ko1_run_en", int'(run_en), 0);
        tick(); tick();
        check("rs_hold_respawn", int'(p1_respawn), 1);
        check("rs_hold_stocks", int'(p1_stocks), 2);
        check("rs_hold_run_en", int'(run_en), 0);
        tick();
        check("rs_end_respawn", int'(p1_respawn), 0);
        check("rs_end_run_en", int'(run_en), 1);
        check("rs_end_stocks", int'(p1_stocks), 2);

        // Simultaneous KO: p1 by y, p2 by x
        safe_pos();
        p1_y = 10'd500; p2_x = 10'd1000;
        tick();
        safe_pos();
        check("dko_p1_stocks", int'(p1_stocks), 1);
        check("dko_p2_stocks", int'(p2_stocks), 2);
        check("dko_p1_respawn", int'(p1_respawn), 1);
        check("dko_p2_respawn", int'(p2_respawn), 1);
        repeat (3) tick();
        check("dko_run_en", int'(run_en), 1);

        // p2 KO to 1 stock (boundary values 630/470 are not KOs)
        p1_x = 10'd630; p1_y = 10'd470;
        p2_y = 10'd471;
        tick();
        safe_pos();
        check("ko2_p1_stocks", int'(p1_stocks), 1);
        check("ko2_p2_stocks", int'(p2_stocks), 1);
        check("ko2_p2_respawn", int'(p2_respawn), 1);
        check("ko2_p1_respawn", int'(p1_respawn), 0);
        repeat (3) tick();

        // p2 KO'd at last stock -> P1 wins, no respawn
        p2_x = 10'd700;
        tick();
        safe_pos();
        check("go1_p2_stocks", int'(p2_stocks), 0);
        check("go1_game_over", int'(game_over), 1);
        check("go1_winner", int'(winner), 1);
        check("go1_p2_respawn", int'(p2_respawn), 0);
        check("go1_run_en", int'(run_en), 0);
        repeat (3) tick();
        check("go1_hold", int'(game_over), 1);
        tick();
        check("go1_idle_game_over", int'(game_over), 0);
        check("go1_idle_winner", int'(winner), 0);
        check("go1_idle_stocks", int'(p1_stocks), 1);

        // New match, bring both to 1 stock, then draw
        to_play();
        check("m2_stocks", int'(p2_stocks), 3);
        for (int k = 0; k < 2; k++) begin
            p1_x = 10'd900; p2_y = 10'd900;
            tick();
            safe_pos();
            repeat (3) tick();
        end
        check("m2_p1_one", int'(p1_stocks), 1);
        check("m2_p2_one", int'(p2_stocks), 1);
        p1_x = 10'd900; p2_x = 10'd900;
        tick();
        safe_pos();
        check("draw_winner", int'(winner), 3);
        check("draw_game_over", int'(game_over), 1);
        check("draw_stocks", int'(p1_stocks), 0);

        // Start during GAME_OVER returns to IDLE next clk, stocks shown
        press();
        check("skip_game_over", int'(game_over), 0);
        check("skip_winner", int'(winner), 0);
        check("skip_countdown", int'(countdown), 0);
        check("skip_stocks", int'(p2_stocks), 0);
        press();
        check("reload_p1", int'(p1_stocks), 3);
        check("reload_p2", int'(p2_stocks), 3);
        check("reload_countdown", int'(countdown), 3);

        // Single P2 win: p1 KO'd three times
        repeat (6) tick();
        for (int k = 0; k < 3; k++) begin
            p1_y = 10'd1023;
            tick();
            safe_pos();
            if (k < 2) repeat (3) tick();
        end
        check("p2win_winner", int'(winner), 2);
        check("p2win_p2_stocks", int'(p2_stocks), 3);
        press();

        // Reset mid-RESPAWN
        to_play();
        p1_x = 10'd700;
        tick();
        safe_pos();
        check("prerst_respawn", int'(p1_respawn), 1);
        @(negedge clk) rst = 1'b1;
        #1;
        check("arst_respawn", int'(p1_respawn), 0);
        check("arst_p1_stocks", int'(p1_stocks), 3);
        check("arst_run_en", int'(run_en), 0);
        check("arst_countdown", int'(countdown), 0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("postrst_idle", int'(countdown), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Round sequencer for a two-player match.
- Gates both players' movement FSMs via run_en.
- Runs the 3-2-1 start countdown, detects blast-zone KOs from player positions, holds KO'd players in respawn, counts stocks, and declares game over / winner.
- Sits between top-level input/position buses and the HUD/renderer. All logic runs on clk; progress advances only on frame_tick.

Parameters:
- STOCKS, 3, lives per player at match start (1..3).
- COUNT_FRAMES, 60, frames per countdown digit (1..255).
- RESPAWN_FRAMES, 90, frames a KO'd player is held before play resumes (1..255).
- GAMEOVER_FRAMES, 180, frames the result is shown before returning to IDLE (1..255).
- BLAST_X_MAX, 630, x_pos strictly above this is a KO (covers unsigned underflow past 0).
- BLAST_Y_MAX, 470, y_pos strictly above this is a KO.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- frame_tick  input  1  one-clk strobe per video frame
- start_button  input  1  synchronous level; rising edge starts/skips
- p1_x  input  10  player 1 x position
- p1_y  input  10  player 1 y position
- p2_x  input  10  player 2 x position
- p2_y  input  10  player 2 y position
- run_en  output  1  movement enable to both movement FSMs
- p1_respawn  output  1  level; player 1 held at spawn
- p2_respawn  output  1  level; player 2 held at spawn
- p1_stocks  output  2  player 1 remaining lives
- p2_stocks  output  2  player 2 remaining lives
- countdown  output  2  digit shown: 3,2,1 in COUNTDOWN, else 0
- game_over  output  1  high in GAME_OVER
- winner  output  2  0=none, 1=P1, 2=P2, 3=draw; valid while game_over

Behaviour:
- Reset (async, immediate):
  - state=IDLE; frame_cnt=0.
  - run_en=0; p1_respawn=0; p2_respawn=0; countdown=0; game_over=0; winner=0.
  - p1_stocks=STOCKS; p2_stocks=STOCKS; start edge register=0.
  - rst mid-match discards everything.
- start_edge = start_button & ~start_prev; start_prev registered every clk (not frame-gated).
- All outputs are registered; they update the clk after the causing event.
- frame_cnt is 8 bits. A phase ends on the frame_tick at which frame_cnt==LIMIT-1; frame_cnt then clears to 0. Otherwise frame_cnt increments on each frame_tick.
- IDLE:
  - run_en=0.
  - On start_edge: reload both stocks to STOCKS; countdown=3; frame_cnt=0; go to COUNTDOWN.
- COUNTDOWN:
  - run_en=0.
  - At each COUNT_FRAMES boundary, countdown decrements. At the boundary while countdown==1: countdown=0, run_en=1, go to PLAY.
  - start_edge is ignored.
- PLAY:
  - run_en=1.
  - On each frame_tick, evaluate koN = (pN_x > BLAST_X_MAX) | (pN_y > BLAST_Y_MAX). Positions are ignored between ticks.
  - Any ko: decrement the stocks of each KO'd player (both at once if simultaneous).
  - If any resulting stock count is 0: go to GAME_OVER with winner = P1 if only p2 hit 0, P2 if only p1 hit 0, 3 if both hit 0.
  - Otherwise: go to RESPAWN; set pN_respawn=1 for each KO'd player; run_en=0; frame_cnt=0.
- RESPAWN:
  - run_en=0; respawn flags held.
  - At the RESPAWN_FRAMES boundary: clear both flags, run_en=1, return to PLAY.
  - KO checks are suspended.
- GAME_OVER:
  - run_en=0; game_over=1.
  - Stocks frozen; winner held.
  - At the GAMEOVER_FRAMES boundary, or on start_edge (whichever comes first): go to IDLE, game_over=0, winner=0.
  - Stocks remain displayed until the next start.
- Stocks never go below 0 (saturate). An unreachable state encoding recovers to IDLE.

Test Plan:
- Params COUNT_FRAMES=2, RESPAWN_FRAMES=3, GAMEOVER_FRAMES=4, STOCKS=3 throughout.
- Reset, pulse start, tick frames -> countdown reads 3,3,2,2,1,1 over six ticks; run_en rises the clk after the 6th tick; stocks=3/3.
- In PLAY, set p1_x=640 on one tick -> p1_stocks=2, p1_respawn=1, run_en=0 for 3 ticks; then respawn=0, run_en=1; p2 unaffected.
- In PLAY, set p1_y=500 and p2_x=1000 on the same tick -> both stocks drop 3->2; both respawn flags high together.
- p2 at 1 stock, p1 at 2, p2 KO'd -> p2_stocks=0, game_over=1, winner=1, no respawn; IDLE after 4 ticks.
- Both at 1 stock, simultaneous KO -> winner=3. Start pressed during GAME_OVER -> IDLE next clk. Second start -> stocks reload to 3.
- Assert rst mid-RESPAWN -> all outputs at reset values immediately. Positions outside the blast zone with no frame_tick -> no stock change.
